// File: rtl/bit_to_bus_deserializer_if.sv
// Serial-in / parallel-out handshake bundle for bit_to_bus_deserializer.
//   s_valid, s_data, s_last : serial bit, its value, and the end-of-frame mark
//   s_ready                 : deserializer accepts the serial bit this cycle
//   p_valid, p_data, p_error: assembled word and its frame-length error flag
//   p_ready                 : consumer accepts the word
// The slave modport is the deserializer's view. The master modport is the
// view of the logic around it, which drives the serial side and consumes words.
interface bit_to_bus_deserializer_if #(
   parameter int WIDTH = 5
);
   logic             s_valid;
   logic             s_data;
   logic             s_last;
   logic             s_ready;
   logic             p_valid;
   logic             p_ready;
   logic [WIDTH-1:0] p_data;
   logic             p_error;

   modport slave (
      input  s_valid, s_data, s_last, p_ready,
      output s_ready, p_valid, p_data, p_error
   );

   modport master (
      output s_valid, s_data, s_last, p_ready,
      input  s_ready, p_valid, p_data, p_error
   );
endinterface

// File: rtl/bit_to_bus_deserializer.sv
// Collects a serial bit stream into WIDTH-bit words and flags frames whose
// length differs from WIDTH.
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   bus   : bit_to_bus_deserializer_if.slave (serial input, parallel output)
// MSB_FIRST=1 places the first bit of a frame in p_data[WIDTH-1].
// MSB_FIRST=0 places it in p_data[0].
//
// state   | meaning
// --------+----------------------------------------------------------------
// COLLECT | shifting bits of a frame into the shifter
// FULL    | word complete but output register occupied; word held in shifter
// DRAIN   | long frame already emitted; discard bits up to and including s_last
module bit_to_bus_deserializer #(
   parameter int WIDTH     = 5,
   parameter int MSB_FIRST = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bit_to_bus_deserializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_FULL,
      ST_DRAIN
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  shifter;
   logic              held_err;
   logic              held_long;
   logic              rdy_en;
   logic              p_valid_q;
   logic [WIDTH-1:0]  p_data_q;
   logic              p_error_q;

   logic              s_ready_i;
   logic              accept;
   logic              pop;
   logic              at_end;
   logic              complete;
   logic              done_err;
   logic              done_long;
   logic              load_now;
   logic [CW-1:0]     idx;
   logic [WIDTH-1:0]  word_next;

   // rdy_en keeps s_ready low during the cycle that follows a reset edge.
   // s_ready is decoded only from registers, so p_ready never reaches it.
   assign s_ready_i   = rdy_en && (state != ST_FULL);
   assign bus.s_ready = s_ready_i;
   assign bus.p_valid = p_valid_q;
   assign bus.p_data  = p_data_q;
   assign bus.p_error = p_error_q;

   always_comb begin
      state_nxt = state;
      accept    = bus.s_valid && s_ready_i;
      pop       = p_valid_q && bus.p_ready;
      at_end    = (cnt == LAST_POS);
      idx       = (MSB_FIRST != 0) ? (LAST_POS - cnt) : cnt;
      word_next = shifter;
      word_next[idx] = bus.s_data;
      complete  = accept && (state == ST_COLLECT) && (bus.s_last || at_end);
      // Only a frame that ends exactly on the last position is error-free.
      done_err  = !(at_end && bus.s_last);
      done_long = at_end && !bus.s_last;
      load_now  = complete && (!p_valid_q || pop);

      unique case (state)
         ST_COLLECT: begin
            if (complete) begin
               if (!load_now)      state_nxt = ST_FULL;
               else if (done_long) state_nxt = ST_DRAIN;
               else                state_nxt = ST_COLLECT;
            end
         end
         ST_FULL: begin
            if (pop) state_nxt = held_long ? ST_DRAIN : ST_COLLECT;
         end
         ST_DRAIN: begin
            if (accept && bus.s_last) state_nxt = ST_COLLECT;
         end
         default: state_nxt = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_COLLECT;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdy_en    <= 1'b0;
         cnt       <= '0;
         shifter   <= '0;
         held_err  <= 1'b0;
         held_long <= 1'b0;
         p_valid_q <= 1'b0;
         p_data_q  <= '0;
         p_error_q <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         // A new load later in this block overrides the drop, giving
         // back-to-back words with no bubble.
         if (pop) p_valid_q <= 1'b0;

         unique case (state)
            ST_COLLECT: begin
               if (accept) begin
                  if (complete) begin
                     cnt <= '0;
                     if (load_now) begin
                        p_data_q  <= word_next;
                        p_error_q <= done_err;
                        p_valid_q <= 1'b1;
                        shifter   <= '0;
                     end else begin
                        shifter   <= word_next;
                        held_err  <= done_err;
                        held_long <= done_long;
                     end
                  end else begin
                     shifter <= word_next;
                     cnt     <= cnt + 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (pop) begin
                  p_data_q  <= shifter;
                  p_error_q <= held_err;
                  p_valid_q <= 1'b1;
                  shifter   <= '0;
               end
            end
            ST_DRAIN: begin
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bit_to_bus_deserializer.sv
module tb_bit_to_bus_deserializer;
   localparam int W = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bit_to_bus_deserializer_if #(.WIDTH(W)) if_m ();
   bit_to_bus_deserializer_if #(.WIDTH(W)) if_l ();

   assign if_l.s_valid = if_m.s_valid;
   assign if_l.s_data  = if_m.s_data;
   assign if_l.s_last  = if_m.s_last;
   assign if_l.p_ready = if_m.p_ready;

   bit_to_bus_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst_n(rst_n), .bus(if_m.slave));
   bit_to_bus_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst_n(rst_n), .bus(if_l.slave));

   int checks = 0;
   int failures = 0;
   logic [W:0] q_m[$];
   logic [W:0] q_l[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: every cycle a word is presented it must match the
   // queue head, which also proves stability while stalled; pop on transfer.
   always @(negedge clk) begin
      if (if_m.p_valid === 1'b1) begin
         if (q_m.size() == 0) begin
            chk("msb_unexpected_word", {58'd0, if_m.p_error, if_m.p_data}, 64'hFFFF);
         end else begin
            chk("msb_word", {58'd0, if_m.p_error, if_m.p_data}, {58'd0, q_m[0]});
            if (if_m.p_ready) void'(q_m.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (if_l.p_valid === 1'b1) begin
         if (q_l.size() == 0) begin
            chk("lsb_unexpected_word", {58'd0, if_l.p_error, if_l.p_data}, 64'hFFFF);
         end else begin
            chk("lsb_word", {58'd0, if_l.p_error, if_l.p_data}, {58'd0, q_l[0]});
            if (if_l.p_ready) void'(q_l.pop_front());
         end
      end
   end

   task automatic expect_word(input logic [W-1:0] dm, input logic [W-1:0] dl, input logic err);
      q_m.push_back({err, dm});
      q_l.push_back({err, dl});
   endtask

   task automatic send_bit(input logic d, input logic l);
      bit ok = 0;
      if_m.s_valid = 1'b1;
      if_m.s_data  = d;
      if_m.s_last  = l;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (if_m.s_ready) begin ok = 1; break; end
      end
      if (!ok) chk("s_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      if_m.s_valid = 1'b0;
      if_m.s_last  = 1'b0;
   endtask

   // bits[n-1] is sent first.
   task automatic send_frame(input logic [15:0] bits, input int n, input logic with_last);
      for (int k = 0; k < n; k++)
         send_bit(bits[n-1-k], with_last && (k == n-1));
   endtask

   initial begin
      if_m.s_valid = 1'b0;
      if_m.s_data  = 1'b0;
      if_m.s_last  = 1'b0;
      if_m.p_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_p_valid", {63'd0, if_m.p_valid}, 64'd0);
      chk("rst_s_ready", {63'd0, if_m.s_ready}, 64'd0);
      chk("rst_p_data",  {59'd0, if_m.p_data}, 64'd0);
      chk("rst_p_error", {63'd0, if_m.p_error}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full frame 1,0,1,1,0: latency one cycle, then p_valid drops.
      expect_word(5'h16, 5'h0D, 1'b0);
      send_frame(16'b10110, 5, 1'b1);
      @(negedge clk);
      chk("lat_p_valid_hi", {63'd0, if_m.p_valid}, 64'd1);
      @(negedge clk);
      chk("lat_p_valid_lo", {63'd0, if_m.p_valid}, 64'd0);
      @(posedge clk); #1;

      // Short frame then a normal frame.
      expect_word(5'h18, 5'h03, 1'b1);
      send_frame(16'b11, 2, 1'b1);
      expect_word(5'h01, 5'h10, 1'b0);
      send_frame(16'b00001, 5, 1'b1);

      // One-bit frame.
      expect_word(5'h10, 5'h01, 1'b1);
      send_frame(16'b1, 1, 1'b1);

      // Long frame: bits 6 and 7 are drained with s_ready high.
      expect_word(5'h11, 5'h11, 1'b1);
      send_frame(16'b10001, 5, 1'b0);
      @(negedge clk);
      chk("drain_s_ready", {63'd0, if_m.s_ready}, 64'd1);
      @(posedge clk); #1;
      send_frame(16'b11, 2, 1'b1);
      expect_word(5'h1F, 5'h1F, 1'b0);
      send_frame(16'b11111, 5, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Backpressure: second word waits in the shifter.
      if_m.p_ready = 1'b0;
      expect_word(5'h19, 5'h13, 1'b0);
      send_frame(16'b11001, 5, 1'b1);
      expect_word(5'h0E, 5'h0E, 1'b0);
      send_frame(16'b01110, 5, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_s_ready_lo", {63'd0, if_m.s_ready}, 64'd0);
         chk("full_p_valid", {63'd0, if_m.p_valid}, 64'd1);
      end
      @(posedge clk); #1;
      if_m.p_ready = 1'b1;
      @(posedge clk); #1;
      if_m.p_ready = 1'b0;
      @(negedge clk);
      chk("pop_s_ready_hi", {63'd0, if_m.s_ready}, 64'd1);
      chk("pop_p_valid_hi", {63'd0, if_m.p_valid}, 64'd1);
      @(posedge clk); #1;
      if_m.p_ready = 1'b1;
      repeat (3) @(posedge clk); #1;

      // Reset in mid-frame discards the partial word.
      send_frame(16'b111, 3, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_p_valid", {63'd0, if_m.p_valid}, 64'd0);
      chk("midrst_s_ready", {63'd0, if_m.s_ready}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      expect_word(5'h0A, 5'h0A, 1'b0);
      send_frame(16'b01010, 5, 1'b1);

      for (int i = 0; i < 50; i++) begin
         if (q_m.size() == 0 && q_l.size() == 0) break;
         @(posedge clk);
      end
      repeat (2) @(posedge clk);
      chk("queues_drained", 64'(q_m.size() + q_l.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bit_to_bus_deserializer.md
Name: bit_to_bus_deserializer

Overview:
- Collects a single-bit serial stream into a WIDTH-bit parallel bus word.
- Inverse of the bus-to-scalar-net splitting used in our netlist fixtures: per-bit nets are reassembled into one bus.
- The first bit received can map to the MSB (descending-range convention) or the LSB (ascending-range convention).
- Sits between a serial link receiver and word-oriented logic; valid/ready handshake on both sides; detects frame-length errors.

Parameters:
- WIDTH, 5, number of bits per parallel word (legal range 2..64).
- MSB_FIRST, 1, 1: first serial bit lands in p_data[WIDTH-1]; 0: first serial bit lands in p_data[0].

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- s_valid  input  1  serial bit present.
- s_data  input  1  serial bit value.
- s_last  input  1  marks final bit of a frame.
- s_ready  output  1  deserializer accepts the bit this cycle.
- p_valid  output  1  parallel word available.
- p_ready  input  1  consumer accepts the word.
- p_data  output  WIDTH  assembled word.
- p_error  output  1  frame-length error flag, qualified by p_valid.

Behaviour:
- Reset: while rst_n is sampled low at a rising edge, the following are cleared on that edge:
  - s_ready=0, p_valid=0, p_data=0, p_error=0.
  - Bit counter=0, shifter=0, state=COLLECT.
  - A partial frame is discarded; a pending output word is dropped.
  - s_ready=1 from the first cycle after rst_n is sampled high.
- Bit transfer: occurs when s_valid && s_ready. Handshake fields are ignored when s_valid=0.
- Word transfer: occurs when p_valid && p_ready.
- Output register rules:
  - One entry.
  - p_data and p_error stay stable while p_valid=1 and p_ready=0.
  - p_valid drops the cycle after the transfer unless a new word loads on the same edge.
- Shifter: holds received bits with a counter 0..WIDTH-1. Bit k of the frame (k=0 first) goes to:
  - index WIDTH-1-k when MSB_FIRST=1;
  - index k when MSB_FIRST=0.
- Unreceived positions are 0.
- States:
  - COLLECT:
    - s_ready=1 unless a completed word is waiting (see FULL).
    - Accepted bit with s_last=1 and k<WIDTH-1 (short frame): word complete, error=1.
    - Accepted bit with k=WIDTH-1 and s_last=1: word complete, error=0.
    - Accepted bit with k=WIDTH-1 and s_last=0 (long frame): word complete, error=1, next state DRAIN.
    - On completion, the counter and shifter clear for the next frame.
  - Word completion:
    - If the output register is empty, or is being popped on the same edge, the word and error load into p_data/p_error and p_valid=1 the next cycle (latency 1 cycle from the completing bit).
    - Otherwise the word is held in the shifter, next state FULL.
  - FULL:
    - s_ready=0.
    - On a pop, the held word loads into the output register the same edge.
    - Next state is DRAIN if that word ended long, else COLLECT.
  - DRAIN:
    - s_ready=1; accepted bits are discarded.
    - An accepted bit with s_last=1 returns the block to COLLECT.
    - No word is produced.
- Simultaneous events:
  - Pop and completion on the same edge: the new word loads with no bubble, and p_valid stays 1.
  - A 1-bit frame (s_last on k=0) is legal as a short frame when WIDTH>1.
- Throughput: one bit per cycle sustained while p_ready=1. Back-to-back frames need no idle cycles.
- Combinational paths: s_ready depends only on registered state. There is no combinational path from p_ready to s_ready.

Test Plan:
- WIDTH=5, MSB_FIRST=1, bits 1,0,1,1,0 with s_last on 5th, p_ready=1 -> one cycle later p_valid=1, p_data=5'h16, p_error=0; p_valid=0 the following cycle.
- WIDTH=5, MSB_FIRST=0, same bit sequence -> p_data=5'h0D, p_error=0.
- MSB_FIRST=1, bits 1,1 with s_last on 2nd -> p_data=5'h18, p_error=1; next 5-bit frame 0,0,0,0,1 with last -> p_data=5'h01, p_error=0.
- MSB_FIRST=1, 7 bits 1,0,0,0,1,1,1 with s_last on 7th, then frame 1,1,1,1,1 with last -> first word 5'h11 with p_error=1; bits 6-7 dropped with s_ready=1; second word 5'h1F with p_error=0.
- p_ready=0, send two full frames back-to-back -> first word held stable; after the second frame's 5th bit, s_ready=0 and stays 0. Then raise p_ready for one cycle -> first word popped, second word loads the same edge, s_ready=1 the next cycle.
- After 3 bits of a frame, drive rst_n=0 for one cycle -> p_valid=0, s_ready=0 during reset. Then a fresh frame 0,1,0,1,0 with last -> p_data=5'h0A, p_error=0, with no residue from the aborted frame.
